// File: rtl/i2c_sync.sv
// i2c_sync: pad-side conditioner for an I2C slave/monitor.
// Each raw line (SDA, SCL) is synchronized through SYNC_STAGES flops and then
// passes through a glitch filter. A level has to stay different from the
// filtered level for FILTER_LEN consecutive cycles before the filtered level
// follows it. The bus conditions are decoded from the current and the previous
// filtered levels, and each one is driven out as a registered one-cycle pulse.
//
// Ports:
//   clk          - system clock (rising edge)
//   rst          - asynchronous active-high reset (bus idles high)
//   sda_in       - raw SDA pin, asynchronous to clk
//   scl_in       - raw SCL pin, asynchronous to clk
//   sda_out      - filtered SDA level
//   scl_out      - filtered SCL level
//   start_out    - one-cycle pulse on START (SDA falls while SCL is stable high)
//   stop_out     - one-cycle pulse on STOP  (SDA rises while SCL is stable high)
//   scl_rise_out - one-cycle pulse on filtered SCL 0->1
//   scl_fall_out - one-cycle pulse on filtered SCL 1->0
module i2c_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_out,
  output logic scl_out,
  output logic start_out,
  output logic stop_out,
  output logic scl_rise_out,
  output logic scl_fall_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
  logic                   sda_s, scl_s;

  logic          sda_f_q, sda_f_d, scl_f_q, scl_f_d;
  logic [CW-1:0] sda_cnt_q, sda_cnt_d, scl_cnt_q, scl_cnt_d;
  logic          sda_past_q, scl_past_q;

  logic start_q, stop_q, rise_q, fall_q;
  logic start_d, stop_d, rise_d, fall_d;

  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign scl_s = scl_sync_q[SYNC_STAGES-1];

  // Synchronizer chains: the raw pin enters at bit 0, the stable copy leaves
  // from the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sync_q <= '1;
      scl_sync_q <= '1;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    end
  end

  // Glitch filters. The counter runs only while the synchronized level
  // disagrees with the filtered level. Any return to agreement clears it, so
  // a pulse shorter than FILTER_LEN cycles is dropped.
  always_comb begin
    sda_f_d   = sda_f_q;
    sda_cnt_d = '0;
    if (sda_s != sda_f_q) begin
      if (sda_cnt_q == CNT_LAST) begin
        sda_f_d = sda_s;
      end else begin
        sda_cnt_d = sda_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = '0;
    if (scl_s != scl_f_q) begin
      if (scl_cnt_q == CNT_LAST) begin
        scl_f_d = scl_s;
      end else begin
        scl_cnt_d = scl_cnt_q + CW'(1);
      end
    end
  end

  // Condition decode on (current, previous) filtered levels. START and STOP
  // both need SCL high in both samples. That makes them exclusive of the SCL
  // edge pulses, and it suppresses them when both lines move in the same cycle.
  always_comb begin
    start_d = scl_f_q & scl_past_q & ~sda_f_q &  sda_past_q;
    stop_d  = scl_f_q & scl_past_q &  sda_f_q & ~sda_past_q;
    rise_d  =  scl_f_q & ~scl_past_q;
    fall_d  = ~scl_f_q &  scl_past_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_f_q    <= 1'b1;
      scl_f_q    <= 1'b1;
      sda_cnt_q  <= '0;
      scl_cnt_q  <= '0;
      sda_past_q <= 1'b1;
      scl_past_q <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sda_f_q    <= sda_f_d;
      scl_f_q    <= scl_f_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_past_q <= sda_f_q;
      scl_past_q <= scl_f_q;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign sda_out      = sda_f_q;
  assign scl_out      = scl_f_q;
  assign start_out    = start_q;
  assign stop_out     = stop_q;
  assign scl_rise_out = rise_q;
  assign scl_fall_out = fall_q;

endmodule

// File: tb/tb_i2c_sync.sv
module tb_i2c_sync;

  localparam int LAT = 5;  // edges from input change to visible pulse (defaults)

  localparam logic [3:0] K_START = 4'b1000;
  localparam logic [3:0] K_STOP  = 4'b0100;
  localparam logic [3:0] K_RISE  = 4'b0010;
  localparam logic [3:0] K_FALL  = 4'b0001;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_in = 1'b1;
  logic scl_in = 1'b1;
  logic sda_out, scl_out, start_out, stop_out, scl_rise_out, scl_fall_out;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  i2c_sync #(.SYNC_STAGES(2), .FILTER_LEN(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sda_in       (sda_in),
    .scl_in       (scl_in),
    .sda_out      (sda_out),
    .scl_out      (scl_out),
    .start_out    (start_out),
    .stop_out     (stop_out),
    .scl_rise_out (scl_rise_out),
    .scl_fall_out (scl_fall_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse kind, due LAT edges after the change made now.
  task automatic expect_ev(input logic [3:0] kind);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle that shows any pulse is matched against the scoreboard.
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t e;
    p = {start_out, stop_out, scl_rise_out, scl_fall_out};
    if (!rst && p != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got pulses %b expected none (cycle %0d)", p, cyc);
      end else begin
        e = exp_q.pop_front();
        if (p !== e.kind || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse: got %b at cycle %0d expected %b at cycle %0d",
                   p, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset held with idle bus
    wait_cycles(3);
    check("rst_sda_out", sda_out, 1);
    check("rst_scl_out", scl_out, 1);
    check("rst_pulses", {start_out, stop_out, scl_rise_out, scl_fall_out}, 0);
    rst = 1'b0;
    wait_cycles(20);
    check("idle_sda_out", sda_out, 1);
    check("idle_scl_out", scl_out, 1);

    // START: SDA falls with SCL high; sda_out follows at edge 4
    sda_in = 1'b0;
    expect_ev(K_START);
    wait_cycles(3);
    check("start_sda_before", sda_out, 1);
    wait_cycles(1);
    check("start_sda_after", sda_out, 0);
    wait_cycles(10);

    // SCL toggles with SDA low, plus SDA moves while SCL low (no pulse)
    scl_in = 1'b0; expect_ev(K_FALL);
    wait_cycles(10);
    check("scl_low", scl_out, 0);
    sda_in = 1'b1; wait_cycles(10);
    sda_in = 1'b0; wait_cycles(10);
    scl_in = 1'b1; expect_ev(K_RISE);
    wait_cycles(10);
    check("scl_high", scl_out, 1);

    // STOP: SDA rises with SCL high
    sda_in = 1'b1; expect_ev(K_STOP);
    wait_cycles(10);
    check("stop_sda_out", sda_out, 1);

    // One-cycle glitches on each line are filtered out
    sda_in = 1'b0; wait_cycles(1); sda_in = 1'b1;
    wait_cycles(10);
    check("glitch_sda_out", sda_out, 1);
    scl_in = 1'b0; wait_cycles(1); scl_in = 1'b1;
    wait_cycles(10);
    check("glitch_scl_out", scl_out, 1);

    // Both lines change together: only the SCL edge is reported
    sda_in = 1'b0; scl_in = 1'b0; expect_ev(K_FALL);
    wait_cycles(10);
    check("both_low", {sda_out, scl_out}, 2'b00);
    sda_in = 1'b1; scl_in = 1'b1; expect_ev(K_RISE);
    wait_cycles(10);
    check("both_high", {sda_out, scl_out}, 2'b11);

    // Reset while the SDA filter count is in flight
    sda_in = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    #1;
    check("midrst_sda_out", sda_out, 1);
    check("midrst_pulses", {start_out, stop_out, scl_rise_out, scl_fall_out}, 0);
    sda_in = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);
    check("post_rst_levels", {sda_out, scl_out}, 2'b11);

    check("missing_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
